// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: interstage pipeline register with a valid/ready handshake.
// A one-entry skid buffer keeps in_ready registered. The block also has a
// synchronous squash (flush) and a saturating back-pressure counter.
// Use one instance per pipeline boundary (ID/EX, EX/MEM, MEM/WB).
//
// Ports
//   clock, reset          rising-edge clock; synchronous active-high reset
//   flush                 squash every held entry on this edge
//   in_valid / in_ready   upstream handshake (in_ready registered, 0 in reset)
//   in_ctrl, in_data0, in_data1, in_rd      upstream payload
//   out_valid / out_ready downstream handshake (out_valid = main entry valid)
//   out_ctrl, out_data0, out_data1, out_rd  main entry payload
//   stall_cnt             cycles with out_valid & !out_ready, saturating
module pipe_reg_skid #(
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [REG_W-1:0]  out_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    // One pipeline entry as held in either register.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data0;
        logic [DATA_W-1:0] data1;
        logic [REG_W-1:0]  rd;
    } entry_t;

    // Occupancy encoding. "Skid full, main empty" has no encoding at all,
    // so it cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    entry_t           m_q, m_d;
    entry_t           s_q, s_d;
    entry_t           in_entry_c;
    logic             rdy_q;
    logic [CNT_W-1:0] stall_q;
    logic             m_v_c;
    logic             accept_c;
    logic             consume_c;
    logic             stall_inc_c;

    assign in_entry_c = '{ctrl: in_ctrl, data0: in_data0, data1: in_data1, rd: in_rd};

    assign m_v_c       = (state_q != EMPTY);
    assign accept_c    = in_valid & in_ready;
    assign consume_c   = m_v_c & out_ready;
    assign stall_inc_c = m_v_c & ~out_ready & ~flush;

    // rdy_q mirrors !skid_valid one register ahead. It is gated with reset
    // so that upstream sees 0 during reset and 1 on the first cycle after.
    assign in_ready  = rdy_q & ~reset;
    assign out_valid = m_v_c;
    assign out_ctrl  = m_q.ctrl;
    assign out_data0 = m_q.data0;
    assign out_data1 = m_q.data1;
    assign out_rd    = m_q.rd;
    assign stall_cnt = stall_q;

    // Next occupancy and payload. Payload only moves with its valid bit,
    // except that flush clears the ctrl fields so no write-back can fire.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
            m_d.ctrl = '0;
            s_d.ctrl = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        m_d     = in_entry_c;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept_c && consume_c) begin
                        m_d = in_entry_c;
                    end else if (accept_c) begin
                        s_d     = in_entry_c;
                        state_d = TWO;
                    end else if (consume_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so the skid entry is promoted first.
                    if (consume_c) begin
                        m_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, payload, ready and stall counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            rdy_q   <= (state_d != TWO);
            if (stall_inc_c && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed and randomised checks of pipe_reg_skid.
// Instance a uses the default widths. Instance b uses CTRL_W=4, DATA_W=64,
// REG_W=6 and CNT_W=3, so it covers the counter saturation case and the
// scoreboard run.
module tb_pipe_reg_skid;

    localparam int unsigned A_CW = 2;
    localparam int unsigned A_DW = 32;
    localparam int unsigned A_RW = 5;
    localparam int unsigned A_NW = 16;
    localparam int unsigned B_CW = 4;
    localparam int unsigned B_DW = 64;
    localparam int unsigned B_RW = 6;
    localparam int unsigned B_NW = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic            a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [A_CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [A_DW-1:0] a_in_data0, a_in_data1, a_out_data0, a_out_data1;
    logic [A_RW-1:0] a_in_rd, a_out_rd;
    logic [A_NW-1:0] a_stall_cnt;

    logic            b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [B_CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [B_DW-1:0] b_in_data0, b_in_data1, b_out_data0, b_out_data1;
    logic [B_RW-1:0] b_in_rd, b_out_rd;
    logic [B_NW-1:0] b_stall_cnt;

    pipe_reg_skid #(.CTRL_W(A_CW), .DATA_W(A_DW), .REG_W(A_RW), .CNT_W(A_NW)) u_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl),
        .in_data0(a_in_data0), .in_data1(a_in_data1), .in_rd(a_in_rd),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data0(a_out_data0), .out_data1(a_out_data1), .out_rd(a_out_rd),
        .stall_cnt(a_stall_cnt)
    );

    pipe_reg_skid #(.CTRL_W(B_CW), .DATA_W(B_DW), .REG_W(B_RW), .CNT_W(B_NW)) u_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
        .in_data0(b_in_data0), .in_data1(b_in_data1), .in_rd(b_in_rd),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data0(b_out_data0), .out_data1(b_out_data1), .out_rd(b_out_rd),
        .stall_cnt(b_stall_cnt)
    );

    typedef struct packed {
        logic [B_CW-1:0] ctrl;
        logic [B_DW-1:0] data0;
        logic [B_DW-1:0] data1;
        logic [B_RW-1:0] rd;
    } b_entry_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [A_CW-1:0] c, input logic [A_RW-1:0] rd,
                           input logic [A_DW-1:0] d0);
        a_in_valid = v;
        a_in_ctrl  = c;
        a_in_rd    = rd;
        a_in_data0 = d0;
        a_in_data1 = ~d0;
    endtask

    initial begin
        b_entry_t q[$];
        b_entry_t e;
        logic     acc, con, fl;

        reset = 1'b1;
        a_flush = 1'b0; b_flush = 1'b0;
        a_drive(1'b1, 2'b00, 5'd0, 32'hDEADBEEF);
        a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_ctrl = '0; b_in_rd = '0;
        b_in_data0 = 64'hDEADBEEF; b_in_data1 = '0; b_out_ready = 1'b0;

        // Reset held for 2 cycles with a valid input present.
        step();
        step();
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data0", 64'(a_out_data0), 64'd0);
        check("rst_out_data1", 64'(a_out_data1), 64'd0);
        check("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
        check("rst_out_rd", 64'(a_out_rd), 64'd0);
        check("rst_stall", 64'(a_stall_cnt), 64'd0);
        reset = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("post_rst_in_ready_b", 64'(b_in_ready), 64'd1);

        // Streaming: one entry per cycle with one cycle of latency.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_drive(1'b1, 2'b01, 5'(i), 32'h100 + 32'(i));
            step();
            check("stream_valid", 64'(a_out_valid), 64'd1);
            check("stream_rd", 64'(a_out_rd), 64'(i));
            check("stream_data0", 64'(a_out_data0), 64'h100 + 64'(i));
        end
        a_in_valid = 1'b0;
        step();
        check("stream_drained", 64'(a_out_valid), 64'd0);
        check("stream_stall", 64'(a_stall_cnt), 64'd0);

        // Back-pressure: two entries held, then an in-order drain.
        a_drive(1'b1, 2'b01, 5'd11, 32'h11);
        step();
        check("bp_first_rd", 64'(a_out_rd), 64'd11);
        a_out_ready = 1'b0;
        a_drive(1'b1, 2'b01, 5'd12, 32'h12);
        step();
        check("bp_two_in_ready", 64'(a_in_ready), 64'd0);
        a_drive(1'b1, 2'b01, 5'd13, 32'h13);
        for (int i = 0; i < 4; i++) step();
        check("bp_held_rd", 64'(a_out_rd), 64'd11);
        check("bp_held_in_ready", 64'(a_in_ready), 64'd0);
        check("bp_stall5", 64'(a_stall_cnt), 64'd5);
        a_out_ready = 1'b1;
        step();
        check("bp_drain1_rd", 64'(a_out_rd), 64'd12);
        check("bp_drain1_data0", 64'(a_out_data0), 64'h12);
        check("bp_drain1_in_ready", 64'(a_in_ready), 64'd1);
        step();
        check("bp_drain2_rd", 64'(a_out_rd), 64'd13);
        check("bp_drain2_valid", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b0;
        step();
        check("bp_empty", 64'(a_out_valid), 64'd0);
        check("bp_stall_final", 64'(a_stall_cnt), 64'd5);

        // Flush while two entries are held.
        a_out_ready = 1'b0;
        a_drive(1'b1, 2'b11, 5'd21, 32'h21);
        step();
        a_drive(1'b1, 2'b11, 5'd22, 32'h22);
        step();
        check("fl_two_in_ready", 64'(a_in_ready), 64'd0);
        check("fl_stall_pre", 64'(a_stall_cnt), 64'd6);
        a_flush = 1'b1;
        a_drive(1'b1, 2'b11, 5'd23, 32'h23);
        step();
        a_flush = 1'b0;
        check("fl_out_valid", 64'(a_out_valid), 64'd0);
        check("fl_out_ctrl", 64'(a_out_ctrl), 64'd0);
        check("fl_rd_held", 64'(a_out_rd), 64'd21);
        check("fl_stall_held", 64'(a_stall_cnt), 64'd6);
        check("fl_in_ready", 64'(a_in_ready), 64'd1);
        a_drive(1'b1, 2'b01, 5'd24, 32'h24);
        step();
        check("fl_next_rd", 64'(a_out_rd), 64'd24);
        check("fl_next_ctrl", 64'(a_out_ctrl), 64'd1);
        check("fl_next_valid", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        check("fl_skid_cleared", 64'(a_out_valid), 64'd0);

        // Flush while ready: the presented input must not be captured.
        a_out_ready = 1'b0;
        a_drive(1'b1, 2'b10, 5'd30, 32'h30);
        step();
        a_flush = 1'b1;
        a_drive(1'b1, 2'b10, 5'd31, 32'h31);
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        check("fl1_out_valid", 64'(a_out_valid), 64'd0);
        step();
        check("fl1_dropped", 64'(a_out_valid), 64'd0);
        check("fl1_stall", 64'(a_stall_cnt), 64'd6);

        // Counter saturation on the 3-bit instance.
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_rd = 6'd5; b_in_ctrl = 4'h9;
        step();
        b_in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("sat_%0d", k), 64'(b_stall_cnt), (k < 7) ? 64'(k) : 64'd7);
        end
        check("sat_rd_stable", 64'(b_out_rd), 64'd5);
        check("sat_ctrl_stable", 64'(b_out_ctrl), 64'h9);
        b_out_ready = 1'b1;
        step();
        check("sat_drained", 64'(b_out_valid), 64'd0);

        // Random handshake with a FIFO scoreboard.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("rnd_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
            check("rnd_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
            check("rnd_illegal", 64'(!b_out_valid && !b_in_ready), 64'd0);
            if (b_out_valid && q.size() > 0) begin
                check("rnd_data0", b_out_data0, q[0].data0);
                check("rnd_data1", b_out_data1, q[0].data1);
                check("rnd_ctrl_rd", 64'({b_out_ctrl, b_out_rd}), 64'({q[0].ctrl, q[0].rd}));
            end
            fl = ($urandom_range(0, 49) == 0);
            b_flush     = fl;
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_out_ready = ($urandom_range(0, 9) < 6);
            b_in_ctrl   = 4'($urandom);
            b_in_data0  = {$urandom, $urandom};
            b_in_data1  = {$urandom, $urandom};
            b_in_rd     = 6'($urandom);
            e   = '{ctrl: b_in_ctrl, data0: b_in_data0, data1: b_in_data1, rd: b_in_rd};
            acc = b_in_valid & b_in_ready;
            con = b_out_valid & b_out_ready;
            step();
            if (fl) begin
                q.delete();
            end else begin
                if (con && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
